fir_mac_sequencer: RTL
======================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 12, sample and coefficient width (signed two's complement).
REQ-002 SHALL have parameter TAPS, default 8, number of filter taps (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse: x holds a new sample.
REQ-006 SHALL have port x  input  BITS  signed input sample, sampled with start.
REQ-007 SHALL have port lock  input  1  high while a coefficient load is in progress; blocks start.
REQ-008 SHALL have port coeff_load_in  input  1  shift-enable for coeff_in.
REQ-009 SHALL have port coeff_in  input  1  serial coefficient bit.
REQ-010 SHALL have port clear_flags  input  1  clears overrun and coeff_err.
REQ-011 SHALL have port y  output  BITS  signed filtered result, held until the next result.
REQ-012 SHALL have port done  output  1  one-cycle pulse: y updated.
REQ-013 SHALL have port busy  output  1  high in MAC and OUT states.
REQ-014 SHALL have port overrun  output  1  sticky: a start was dropped.
REQ-015 SHALL have port coeff_err  output  1  sticky: a coefficient shift was dropped.

Function
REQ-016 SHALL implement a single shared multiplier-accumulator, a TAPS-entry sample ring buffer, a write pointer wr_ptr (log2 TAPS bits), a TAPS x BITS coefficient bank and an FSM with states IDLE, MAC, OUT.
REQ-017 IDLE: start=1 and lock=0 SHALL write x to ring[wr_ptr], clear the accumulator, load tap counter k=0, enter MAC.
REQ-018 MAC: each cycle SHALL add coeff[k] * ring[(wr_ptr - k) mod TAPS] to the accumulator and increment k; after k=TAPS-1 SHALL enter OUT.
REQ-019 Accumulator SHALL be 2*BITS + log2(TAPS) bits signed; no intermediate overflow.
REQ-020 OUT: y SHALL take acc arithmetic-shifted right by BITS-1 (floor), saturated to [-2^(BITS-1), 2^(BITS-1)-1]; done SHALL pulse this cycle; wr_ptr SHALL increment mod TAPS (wrap TAPS-1 -> 0); next state IDLE.
REQ-021 Latency: done SHALL be high exactly TAPS+1 cycles after the cycle in which the accepted start was high; done high for exactly one cycle per accepted start.
REQ-022 start while busy=1 or lock=1 SHALL be dropped (no ring write, no done) and SHALL set overrun.
REQ-023 Coefficient shift (coeff_load_in=1 while busy=0) SHALL shift the vector {coeff[0],...,coeff[TAPS-1]} left by one with coeff_in entering the LSB of coeff[TAPS-1]; after TAPS*BITS shifts the first bit is the MSB of coeff[0].
REQ-024 coeff_load_in=1 while busy=1 SHALL be dropped, leave coefficients unchanged, and set coeff_err; an in-flight computation SHALL always use unchanged coefficients.
REQ-025 Shifting SHALL not depend on lock; lock only gates start.
REQ-026 start and coeff_load_in both high in IDLE with lock=0: both SHALL take effect; the computation SHALL use the post-shift coefficients.
REQ-027 clear_flags=1 SHALL clear overrun and coeff_err; a set event in the same cycle SHALL win (flag reads 1).
REQ-028 y SHALL change only in OUT.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, y=0, done=0, busy=0, overrun=0, coeff_err=0, wr_ptr=0, k=0, accumulator=0, all ring entries 0, all coefficients 0.
REQ-030 Reset asserted mid-MAC SHALL abort the computation; no done SHALL follow deassertion.
REQ-031 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 Shift coeff[0]=0x7FF, rest 0 (96 bits); start x=1000 -> done exactly 9 cycles later, y=999.
REQ-033 All coeffs 0x400; eight starts x=0x7FF spaced 10 cycles -> y=1023,2047,2047,... (8th saturates at 2047); wr_ptr wraps to 0.
REQ-034 All coeffs 0x7FF; eight starts x=-2048 -> 8th y=-2048 (negative saturation), no overflow wrap.
REQ-035 start at cycle 3 of MAC, and start with lock=1 in IDLE -> both dropped, overrun=1, one done only; clear_flags -> overrun=0.
REQ-036 coeff_load_in during MAC -> coeff_err=1, coefficients unchanged (rerun gives identical y).
REQ-037 rst_n low during MAC cycle 4 -> y=0, done never pulses, ring/coeffs zero; next start x=500 yields y=0.

Source files
------------

// File: rtl/fir_mac_if.sv
// Sample/result handshake between a sample source and fir_mac_sequencer.
interface fir_mac_if #(parameter int BITS = 12) ();
   logic            start;
   logic [BITS-1:0] x;
   logic [BITS-1:0] y;
   logic            done;
   logic            busy;

   modport master (output start, x, input  y, done, busy);
   modport slave  (input  start, x, output y, done, busy);
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared MAC walks TAPS ring-buffer samples per accepted start,
// with a serially loaded coefficient bank and sticky drop flags.
//
// state | meaning
// IDLE  | waiting for start; coefficient shifts accepted
// MAC   | one tap per cycle, k = 0 .. TAPS-1
// OUT   | y/done presented, write pointer advances
module fir_mac_sequencer #(
   parameter int BITS = 12,
   parameter int TAPS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   fir_mac_if.slave     bus,
   input  logic         lock,
   input  logic         coeff_load_in,
   input  logic         coeff_in,
   input  logic         clear_flags,
   output logic         overrun,
   output logic         coeff_err
);
   localparam int LG = $clog2(TAPS);
   localparam int AW = 2*BITS + LG;
   localparam logic [LG-1:0]          K_LAST = LG'(TAPS-1);
   localparam logic signed [AW-1:0]   Y_MAX  = {{(AW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
   localparam logic signed [AW-1:0]   Y_MIN  = {{(AW-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
   localparam logic signed [BITS-1:0] Y_MAX_B = {1'b0, {(BITS-1){1'b1}}};
   localparam logic signed [BITS-1:0] Y_MIN_B = {1'b1, {(BITS-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t                  state_q, state_d;
   logic [LG-1:0]           k_q, k_d;
   logic [LG-1:0]           wr_ptr_q, wr_ptr_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic signed [BITS-1:0]  ring_q [TAPS];
   logic signed [BITS-1:0]  ring_d [TAPS];
   logic signed [BITS-1:0]  coeff_q [TAPS];
   logic signed [BITS-1:0]  coeff_d [TAPS];
   logic signed [BITS-1:0]  y_q, y_d;
   logic                    done_q, done_d;
   logic                    overrun_q, overrun_d;
   logic                    coeff_err_q, coeff_err_d;

   logic                    busy;
   logic                    start_ok;
   logic                    shift_ok;
   logic [LG-1:0]           rd_idx;
   logic signed [BITS-1:0]  c_sel;
   logic signed [BITS-1:0]  s_sel;
   logic signed [2*BITS-1:0] prod;
   logic signed [AW-1:0]    acc_sh;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      wr_ptr_d    = wr_ptr_q;
      acc_d       = acc_q;
      ring_d      = ring_q;
      coeff_d     = coeff_q;
      y_d         = y_q;
      done_d      = 1'b0;
      acc_sh      = '0;

      busy     = (state_q != S_IDLE);
      start_ok = bus.start & ~lock & ~busy;
      shift_ok = coeff_load_in & ~busy;

      rd_idx = wr_ptr_q - k_q;
      c_sel  = coeff_q[k_q];
      s_sel  = ring_q[rd_idx];
      prod   = c_sel * s_sel;

      overrun_d   = (overrun_q & ~clear_flags) | (bus.start & (busy | lock));
      coeff_err_d = (coeff_err_q & ~clear_flags) | (coeff_load_in & busy);

      // The whole bank behaves as one long shift register, coeff[0] holding the oldest bits.
      if (shift_ok) begin
         for (int i = 0; i < TAPS-1; i++) begin
            coeff_d[i] = {coeff_q[i][BITS-2:0], coeff_q[i+1][BITS-1]};
         end
         coeff_d[TAPS-1] = {coeff_q[TAPS-1][BITS-2:0], coeff_in};
      end

      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               ring_d[wr_ptr_q] = bus.x;
               acc_d            = '0;
               k_d              = '0;
               state_d          = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_q + {{LG{prod[2*BITS-1]}}, prod};
            k_d   = k_q + 1'b1;
            // Result is registered on the last tap so y is already valid during OUT.
            if (k_q == K_LAST) begin
               acc_sh = acc_d >>> (BITS-1);
               if (acc_sh > Y_MAX)      y_d = Y_MAX_B;
               else if (acc_sh < Y_MIN) y_d = Y_MIN_B;
               else                     y_d = acc_sh[BITS-1:0];
               done_d  = 1'b1;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         wr_ptr_q    <= '0;
         acc_q       <= '0;
         y_q         <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         coeff_err_q <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            ring_q[i]  <= '0;
            coeff_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         wr_ptr_q    <= wr_ptr_d;
         acc_q       <= acc_d;
         y_q         <= y_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
         coeff_err_q <= coeff_err_d;
         ring_q      <= ring_d;
         coeff_q     <= coeff_d;
      end
   end

   assign bus.y     = y_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy;
   assign overrun   = overrun_q;
   assign coeff_err = coeff_err_q;
endmodule
